// File: rtl/boneless_trace_pkg.sv
// rtl/boneless_trace_pkg.sv - shared types for the boneless retirement trace buffer
// Purpose: record layout, FSM state encoding and record width used by the
//          trace buffer top and its FIFO.
// Ports:   none (package)
package boneless_trace_pkg;

  localparam int TRACE_W = 88;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } trace_state_e;

  // MSB first: pad, ext pairing, memory write, flags, insn, pc (pc at [15:0]).
  typedef struct packed {
    logic        pad;
    logic        ext_r;
    logic        ext_w;
    logic [15:0] ext_addr;
    logic        mem_w_en;
    logic [15:0] mem_w_addr;
    logic [15:0] mem_w_data;
    logic [3:0]  flags;
    logic [15:0] insn;
    logic [15:0] pc;
  } trace_rec_t;

endpackage

// File: rtl/boneless_trace_fifo.sv
// rtl/boneless_trace_fifo.sv - circular record store with wrap-bit pointers
// Purpose: DEPTH-entry FIFO of trace records; head is presented combinationally
//          from the register array and forced to zero while empty.
// Ports:   clk, rst_n      clock, async active-low reset
//          i_clear         drop all contents (pointers to zero)
//          i_push, i_data  write record at wptr
//          i_pop           advance rptr (caller guarantees non-empty)
//          o_data          head record, zero when empty
//          o_level         records held (AW+1 bits)
//          o_full, o_empty status
module boneless_trace_fifo
  import boneless_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [TRACE_W-1:0] i_data,
  output logic [TRACE_W-1:0] o_data,
  output logic [AW:0]        o_level,
  output logic               o_full,
  output logic               o_empty
);

  logic [TRACE_W-1:0] r_mem [DEPTH];
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PTR_ONE;
      if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the empty flag masks whatever the slots hold.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_level = r_wptr - r_rptr;
  assign o_data  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/boneless_trace_buffer.sv
// rtl/boneless_trace_buffer.sv - retirement trace capture with ext-access pairing
// Purpose: captures one record per fi_stb into a circular FIFO and streams it to
//          a debug host over valid/ready; keeps FSM, ext latch and drop counter.
// Ports:   clk, rst_n                  clock, async active-low reset
//          fi_*                        core retirement port
//          ctl_arm/ctl_stop/ctl_wrap   capture control
//          tr_valid/tr_ready/tr_data   record stream
//          tr_level/tr_drops/tr_state  status
module boneless_trace_buffer
  import boneless_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fi_stb,
  input  logic [15:0]        fi_pc,
  input  logic [15:0]        fi_insn,
  input  logic [3:0]         fi_flags,
  input  logic               fi_mem_w_en,
  input  logic [15:0]        fi_mem_w_addr,
  input  logic [15:0]        fi_mem_w_data,
  input  logic               fi_ext_r_en,
  input  logic               fi_ext_w_en,
  input  logic [15:0]        fi_ext_addr,
  input  logic               ctl_arm,
  input  logic               ctl_stop,
  input  logic               ctl_wrap,
  output logic               tr_valid,
  input  logic               tr_ready,
  output logic [TRACE_W-1:0] tr_data,
  output logic [AW:0]        tr_level,
  output logic [15:0]        tr_drops,
  output logic [1:0]         tr_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_drops;
  logic        r_pend_r;
  logic        r_pend_w;
  logic [15:0] r_pend_addr;

  logic       w_run, w_ext_now, w_pend;
  logic       w_full, w_empty, w_pop;
  logic       w_capture, w_overwrite, w_reject, w_push, w_fifo_pop;
  logic       w_drop_inc;
  trace_rec_t w_rec;

  assign w_run     = (r_state == ST_RUN);
  assign w_ext_now = fi_ext_r_en | fi_ext_w_en;
  assign w_pend    = r_pend_r | r_pend_w;
  assign w_pop     = tr_valid & tr_ready;

  // Arm clears the FIFO on this edge, so nothing is captured alongside it.
  assign w_capture = w_run & fi_stb & ~ctl_arm;
  // A host pop in the same cycle frees a slot, so a full FIFO only loses data
  // when nobody is draining it.
  assign w_overwrite = w_capture & w_full & ~w_pop & ctl_wrap;
  assign w_reject    = w_capture & w_full & ~w_pop & ~ctl_wrap;
  assign w_push      = w_capture & ~w_reject;
  assign w_fifo_pop  = w_pop | w_overwrite;

  // Retires while parked in FULL still count as lost; IDLE never counts.
  assign w_drop_inc = ~ctl_arm & (w_overwrite | w_reject
                    | ((r_state == ST_FULL) & fi_stb)
                    | (w_run & w_ext_now & ~fi_stb & w_pend));

  always_comb begin
    w_rec            = '0;
    w_rec.pad        = 1'b0;
    w_rec.ext_r      = r_pend_r | fi_ext_r_en;
    w_rec.ext_w      = r_pend_w | fi_ext_w_en;
    w_rec.ext_addr   = w_ext_now ? fi_ext_addr : r_pend_addr;
    w_rec.mem_w_en   = fi_mem_w_en;
    w_rec.mem_w_addr = fi_mem_w_addr;
    w_rec.mem_w_data = fi_mem_w_data;
    w_rec.flags      = fi_flags;
    w_rec.insn       = fi_insn;
    w_rec.pc         = fi_pc;
  end

  boneless_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (ctl_arm),
    .i_push  (w_push),
    .i_pop   (w_fifo_pop),
    .i_data  (w_rec),
    .o_data  (tr_data),
    .o_level (tr_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign tr_valid = ~w_empty;
  assign tr_drops = r_drops;
  assign tr_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else if (ctl_arm) begin
      r_state <= ST_RUN;
    end else if (ctl_stop) begin
      r_state <= ST_IDLE;
    end else if (w_reject) begin
      r_state <= ST_FULL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drops <= '0;
    end else if (ctl_arm) begin
      r_drops <= '0;
    end else if (w_drop_inc && r_drops != 16'hFFFF) begin
      r_drops <= r_drops + 16'd1;
    end
  end

  // Pending ext access waits for the retire it belongs to; a newer strobe
  // replaces an unclaimed one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_r    <= 1'b0;
      r_pend_w    <= 1'b0;
      r_pend_addr <= '0;
    end else if (ctl_arm) begin
      r_pend_r    <= 1'b0;
      r_pend_w    <= 1'b0;
      r_pend_addr <= '0;
    end else if (w_run) begin
      if (fi_stb) begin
        r_pend_r    <= 1'b0;
        r_pend_w    <= 1'b0;
        r_pend_addr <= '0;
      end else if (w_ext_now) begin
        r_pend_r    <= fi_ext_r_en;
        r_pend_w    <= fi_ext_w_en;
        r_pend_addr <= fi_ext_addr;
      end
    end
  end

endmodule

// File: tb/tb_boneless_trace_buffer.sv
// tb/tb_boneless_trace_buffer.sv - directed self-checking bench for boneless_trace_buffer
module tb_boneless_trace_buffer;

  logic        clk;
  logic        rst_n;
  logic        fi_stb;
  logic [15:0] fi_pc;
  logic [15:0] fi_insn;
  logic [3:0]  fi_flags;
  logic        fi_mem_w_en;
  logic [15:0] fi_mem_w_addr;
  logic [15:0] fi_mem_w_data;
  logic        fi_ext_r_en;
  logic        fi_ext_w_en;
  logic [15:0] fi_ext_addr;
  logic        ctl_arm;
  logic        ctl_stop;
  logic        ctl_wrap;
  logic        tr_valid;
  logic        tr_ready;
  logic [87:0] tr_data;
  logic [4:0]  tr_level;
  logic [15:0] tr_drops;
  logic [1:0]  tr_state;

  int errors = 0;
  int checks = 0;

  boneless_trace_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fi_stb        (fi_stb),
    .fi_pc         (fi_pc),
    .fi_insn       (fi_insn),
    .fi_flags      (fi_flags),
    .fi_mem_w_en   (fi_mem_w_en),
    .fi_mem_w_addr (fi_mem_w_addr),
    .fi_mem_w_data (fi_mem_w_data),
    .fi_ext_r_en   (fi_ext_r_en),
    .fi_ext_w_en   (fi_ext_w_en),
    .fi_ext_addr   (fi_ext_addr),
    .ctl_arm       (ctl_arm),
    .ctl_stop      (ctl_stop),
    .ctl_wrap      (ctl_wrap),
    .tr_valid      (tr_valid),
    .tr_ready      (tr_ready),
    .tr_data       (tr_data),
    .tr_level      (tr_level),
    .tr_drops      (tr_drops),
    .tr_state      (tr_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fi_stb = 0; fi_pc = 0; fi_insn = 0; fi_flags = 0;
    fi_mem_w_en = 0; fi_mem_w_addr = 0; fi_mem_w_data = 0;
    fi_ext_r_en = 0; fi_ext_w_en = 0; fi_ext_addr = 0;
    ctl_arm = 0; ctl_stop = 0; ctl_wrap = 0; tr_ready = 0;
  endtask

  task automatic arm();
    ctl_arm = 1;
    step();
    ctl_arm = 0;
  endtask

  task automatic retire(input logic [15:0] pc, input logic [15:0] insn);
    fi_stb = 1; fi_pc = pc; fi_insn = insn;
    step();
    fi_stb = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    step(); step();
    checks++; if (tr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", tr_valid); end
    checks++; if (tr_data !== 88'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", tr_data); end
    checks++; if (tr_level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", tr_level); end
    checks++; if (tr_drops !== 16'd0) begin errors++; $display("FAIL reset_drops got=%0d exp=0", tr_drops); end
    checks++; if (tr_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", tr_state); end
    @(negedge clk);
    rst_n = 1;
    step();
    retire(16'h0ABC, 16'h0);
    checks++; if (tr_level !== 5'd0) begin errors++; $display("FAIL idle_ignore got=%0d exp=0", tr_level); end
  endtask

  task automatic test_capture();
    logic [87:0] exp_rec;
    arm();
    checks++; if (tr_state !== 2'd1) begin errors++; $display("FAIL arm_state got=%0d exp=1", tr_state); end
    tr_ready = 1;
    for (int i = 0; i < 3; i++) begin
      fi_flags      = (i == 0) ? 4'hA : 4'h0;
      fi_mem_w_en   = (i == 0);
      fi_mem_w_addr = (i == 0) ? 16'h0200 : 16'h0;
      fi_mem_w_data = (i == 0) ? 16'hBEEF : 16'h0;
      exp_rec = {1'b0, 1'b0, 1'b0, 16'h0, fi_mem_w_en, fi_mem_w_addr, fi_mem_w_data,
                 fi_flags, 16'h1000 + 16'(i), 16'h0010 + 16'(i)};
      retire(16'h0010 + 16'(i), 16'h1000 + 16'(i));
      checks++;
      if (tr_valid !== 1'b1 || tr_data !== exp_rec) begin
        errors++; $display("FAIL capture_rec%0d got=%b/%h exp=1/%h", i, tr_valid, tr_data, exp_rec);
      end
    end
    fi_flags = 0; fi_mem_w_en = 0; fi_mem_w_addr = 0; fi_mem_w_data = 0;
    step();
    checks++; if (tr_valid !== 1'b0) begin errors++; $display("FAIL capture_drained got=%0b exp=0", tr_valid); end
    checks++; if (tr_drops !== 16'd0) begin errors++; $display("FAIL capture_drops got=%0d exp=0", tr_drops); end
  endtask

  task automatic test_ext_pairing();
    tr_ready = 1;
    fi_ext_r_en = 1; fi_ext_addr = 16'h0042;
    step();
    fi_ext_r_en = 0; fi_ext_addr = 0;
    retire(16'h0020, 16'h3000);
    checks++;
    if (tr_data[86] !== 1'b1 || tr_data[84:69] !== 16'h0042 || tr_data[31:16] !== 16'h3000) begin
      errors++; $display("FAIL ext_ldx got r=%0b addr=%h insn=%h exp r=1 addr=0042 insn=3000", tr_data[86], tr_data[84:69], tr_data[31:16]);
    end
    retire(16'h0021, 16'h0000);
    checks++;
    if (tr_data[86] !== 1'b0 || tr_data[84:69] !== 16'h0 || tr_data[15:0] !== 16'h0021) begin
      errors++; $display("FAIL ext_cleared got r=%0b addr=%h pc=%h exp r=0 addr=0 pc=0021", tr_data[86], tr_data[84:69], tr_data[15:0]);
    end
    step();
    fi_ext_w_en = 1; fi_ext_addr = 16'h0001;
    step();
    fi_ext_addr = 16'h0002;
    step();
    fi_ext_w_en = 0; fi_ext_addr = 0;
    checks++; if (tr_drops !== 16'd1) begin errors++; $display("FAIL ext_overlap_drop got=%0d exp=1", tr_drops); end
    retire(16'h0022, 16'h4000);
    checks++;
    if (tr_data[85] !== 1'b1 || tr_data[86] !== 1'b0 || tr_data[84:69] !== 16'h0002) begin
      errors++; $display("FAIL ext_newer got w=%0b r=%0b addr=%h exp w=1 r=0 addr=0002", tr_data[85], tr_data[86], tr_data[84:69]);
    end
    step();
  endtask

  task automatic test_full_nowrap();
    tr_ready = 0;
    ctl_wrap = 0;
    arm();
    for (int i = 0; i < 18; i++) retire(16'h0100 + 16'(i), 16'h0);
    checks++; if (tr_level !== 5'd16) begin errors++; $display("FAIL nowrap_level got=%0d exp=16", tr_level); end
    checks++; if (tr_drops !== 16'd2) begin errors++; $display("FAIL nowrap_drops got=%0d exp=2", tr_drops); end
    checks++; if (tr_state !== 2'd2) begin errors++; $display("FAIL nowrap_state got=%0d exp=2", tr_state); end
    retire(16'h0200, 16'h0);
    checks++;
    if (tr_drops !== 16'd3 || tr_level !== 5'd16 || tr_state !== 2'd2) begin
      errors++; $display("FAIL full_stb got drops=%0d lvl=%0d st=%0d exp 3/16/2", tr_drops, tr_level, tr_state);
    end
    tr_ready = 1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (tr_valid !== 1'b1 || tr_data[15:0] !== 16'h0100 + 16'(i)) begin
        errors++; $display("FAIL nowrap_drain%0d got=%b/%h exp=1/%h", i, tr_valid, tr_data[15:0], 16'h0100 + 16'(i));
      end
      step();
    end
    tr_ready = 0;
    checks++; if (tr_valid !== 1'b0 || tr_level !== 5'd0) begin errors++; $display("FAIL nowrap_empty got=%b/%0d exp=0/0", tr_valid, tr_level); end
  endtask

  task automatic test_full_wrap();
    tr_ready = 0;
    ctl_wrap = 1;
    arm();
    for (int i = 0; i < 20; i++) retire(16'(i), 16'h0);
    checks++; if (tr_drops !== 16'd4) begin errors++; $display("FAIL wrap_drops got=%0d exp=4", tr_drops); end
    checks++; if (tr_state !== 2'd1) begin errors++; $display("FAIL wrap_state got=%0d exp=1", tr_state); end
    checks++;
    if (tr_level !== 5'd16 || tr_data[15:0] !== 16'd4) begin
      errors++; $display("FAIL wrap_head got lvl=%0d pc=%h exp 16/0004", tr_level, tr_data[15:0]);
    end
  endtask

  task automatic test_back_to_back();
    tr_ready = 1;
    retire(16'd20, 16'h0);
    tr_ready = 0;
    checks++;
    if (tr_drops !== 16'd4 || tr_level !== 5'd16 || tr_data[15:0] !== 16'd5) begin
      errors++; $display("FAIL popush got drops=%0d lvl=%0d pc=%h exp 4/16/0005", tr_drops, tr_level, tr_data[15:0]);
    end
    tr_ready = 1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (tr_valid !== 1'b1 || tr_data[15:0] !== 16'(5 + i)) begin
        errors++; $display("FAIL wrap_drain%0d got=%b/%h exp=1/%h", i, tr_valid, tr_data[15:0], 16'(5 + i));
      end
      step();
    end
    tr_ready = 0;
    ctl_wrap = 0;
    checks++; if (tr_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%0b exp=0", tr_valid); end
  endtask

  task automatic test_async_reset();
    arm();
    retire(16'h0300, 16'h0);
    retire(16'h0301, 16'h0);
    fi_ext_r_en = 1; fi_ext_addr = 16'h0077;
    step(); step();
    fi_ext_r_en = 0; fi_ext_addr = 0;
    checks++;
    if (tr_drops !== 16'd1 || tr_level !== 5'd2) begin
      errors++; $display("FAIL prereset got drops=%0d lvl=%0d exp 1/2", tr_drops, tr_level);
    end
    fi_stb = 1; fi_pc = 16'h0302;
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (tr_valid !== 1'b0 || tr_data !== 88'h0 || tr_level !== 5'd0 || tr_drops !== 16'd0 || tr_state !== 2'd0) begin
      errors++; $display("FAIL async_reset got v=%b lvl=%0d drops=%0d st=%0d data=%h exp all zero", tr_valid, tr_level, tr_drops, tr_state, tr_data);
    end
    clear_inputs();
    step(); step();
    @(negedge clk);
    rst_n = 1;
    retire(16'h0400, 16'h0);
    step();
    checks++;
    if (tr_state !== 2'd0 || tr_valid !== 1'b0 || tr_level !== 5'd0) begin
      errors++; $display("FAIL post_reset got st=%0d v=%b lvl=%0d exp 0/0/0", tr_state, tr_valid, tr_level);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_ext_pairing();
    test_full_nowrap();
    test_full_wrap();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
